// File: rtl/data_mem_arbiter.sv
// ============================================================================
// data_mem_arbiter
// Two-port round-robin arbiter in front of a single-port, word-addressed data
// memory with a registered read. Port 0 is the CPU load/store path, port 1 the
// loader/debug path. Out-of-range word addresses are answered with an error
// instead of being forwarded to the memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_mem_arbiter #(
    parameter int unsigned    DW       = 32,
    parameter int unsigned    AW       = 32,
    parameter logic [AW-1:0]  MAX_ADDR = 32'h1FFFF
) (
    input  logic          clk,
    input  logic          rst_n,
    // Port 0: CPU load/store
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    output logic          err0,
    // Port 1: loader/debug
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          err1,
    // Memory side
    output logic [AW-1:0] mem_a,
    output logic          mem_we,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t state;
    logic   last_gnt;   // port granted most recently; the other wins a tie
    logic   owner;      // port that owns the outstanding read
    logic   err_q;      // outstanding read was out of range

    logic          sel;
    logic          grant;
    logic          rsp;
    logic          we_w;
    logic          range_err;
    logic [AW-1:0] addr_w;
    logic [DW-1:0] wdata_w;

    // Winner selection and memory request mux; outputs are gated by reset so
    // everything drops to zero the moment rst_n goes low.
    always_comb begin
        sel       = (req0 && req1) ? ~last_gnt : req1;
        addr_w    = sel ? addr1  : addr0;
        wdata_w   = sel ? wdata1 : wdata0;
        we_w      = sel ? we1    : we0;
        range_err = (addr_w > MAX_ADDR);
        grant     = rst_n && (state == IDLE) && (req0 || req1);
        rsp       = rst_n && (state == RD_WAIT);

        gnt0      = grant && !sel;
        gnt1      = grant &&  sel;
        mem_a     = grant ? addr_w  : '0;
        mem_wd    = grant ? wdata_w : '0;
        mem_we    = grant && we_w && !range_err;

        rvalid0   = rsp && !owner;
        rvalid1   = rsp &&  owner;
        rdata0    = (rvalid0 && !err_q) ? mem_rd : '0;
        rdata1    = (rvalid1 && !err_q) ? mem_rd : '0;
        // Writes flag the error with the grant, reads with the response
        err0      = (gnt0 && we_w && range_err) || (rvalid0 && err_q);
        err1      = (gnt1 && we_w && range_err) || (rvalid1 && err_q);
    end

    // Arbitration state: round-robin pointer and the one-cycle read wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            owner    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        last_gnt <= sel;
                        if (!we_w) begin
                            owner <= sel;
                            err_q <= range_err;
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// ============================================================================
// tb_data_mem_arbiter
// Directed self-checking bench for data_mem_arbiter with a small registered
// memory model behind the memory port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1, mem_we;
    logic [31:0] rdata0, rdata1, mem_a, mem_wd;
    logic [31:0] mem_rd = '0;
    logic [31:0] mem [16];

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Registered single-port memory; low address bits are enough for the
    // handful of addresses the bench touches (5, 10, 11, 0x1FFFF).
    always @(posedge clk) begin
        if (mem_we) mem[mem_a[3:0]] <= mem_wd;
        mem_rd <= mem[mem_a[3:0]];
    end

    // Advance to the next falling edge, where inputs change and the
    // combinational outputs settle before sampling.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd3; wdata0 = 32'h1234;
        #1;
        n_checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b exp 0000000", {gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we});
        end
        n_checks++;
        if ({mem_a, mem_wd, rdata0, rdata1} !== 128'b0) begin
            n_fail++;
            $display("FAIL reset_data: mem_a=%h mem_wd=%h rdata0=%h rdata1=%h exp 0", mem_a, mem_wd, rdata0, rdata1);
        end
        req0 = 1'b0; we0 = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        step();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd5; wdata0 = 32'hDEADBEEF;
        #1;
        n_checks++;
        if ({gnt0, gnt1, mem_we, err0} !== 4'b1010) begin
            n_fail++;
            $display("FAIL wr_ctrl: gnt0,gnt1,mem_we,err0 got %b exp 1010", {gnt0, gnt1, mem_we, err0});
        end
        n_checks++;
        if (mem_a !== 32'd5 || mem_wd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wr_bus: mem_a=%h mem_wd=%h exp 5 deadbeef", mem_a, mem_wd);
        end
    endtask

    task automatic test_read();
        step();
        we0 = 1'b0;
        #1;
        n_checks++;
        if ({gnt0, gnt1, mem_we} !== 3'b100 || mem_a !== 32'd5) begin
            n_fail++;
            $display("FAIL rd_gnt: gnt0,gnt1,mem_we got %b mem_a=%h exp 100 5", {gnt0, gnt1, mem_we}, mem_a);
        end
        step();
        req0 = 1'b0;
        #1;
        n_checks++;
        if ({rvalid0, rvalid1, gnt0, gnt1, err0} !== 5'b10000 || rdata0 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rd_rsp: rv0,rv1,g0,g1,e0 got %b rdata0=%h exp 10000 deadbeef", {rvalid0, rvalid1, gnt0, gnt1, err0}, rdata0);
        end
        step();
        #1;
        n_checks++;
        if (rvalid0 !== 1'b0 || rdata0 !== 32'h0) begin
            n_fail++;
            $display("FAIL rd_idle: rvalid0=%b rdata0=%h exp 0 0", rvalid0, rdata0);
        end
    endtask

    task automatic test_round_robin_write();
        logic [1:0] exp_g;
        logic [31:0] exp_wd;
        // One port-1 write first so that port 0 is next in line
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd11; wdata1 = 32'h0;
        step();
        req1 = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd10; wdata0 = 32'hAAAA0000;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd11; wdata1 = 32'hBBBB1111;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) step();
            #1;
            exp_g  = (i % 2 == 0) ? 2'b10 : 2'b01;
            exp_wd = (i % 2 == 0) ? 32'hAAAA0000 : 32'hBBBB1111;
            n_checks++;
            if ({gnt0, gnt1} !== exp_g || mem_wd !== exp_wd || mem_we !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_wr[%0d]: gnt0,gnt1=%b mem_wd=%h mem_we=%b exp %b %h 1", i, {gnt0, gnt1}, mem_wd, mem_we, exp_g, exp_wd);
            end
        end
        step();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    endtask

    task automatic test_both_read();
        req0 = 1'b1; addr0 = 32'd10; req1 = 1'b1; addr1 = 32'd11;
        #1;
        n_checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            n_fail++;
            $display("FAIL brd_n: gnt0,gnt1 got %b exp 10", {gnt0, gnt1});
        end
        step();
        req0 = 1'b0;
        #1;
        n_checks++;
        if ({rvalid0, rvalid1, gnt0, gnt1} !== 4'b1000 || rdata0 !== 32'hAAAA0000) begin
            n_fail++;
            $display("FAIL brd_n1: rv0,rv1,g0,g1 got %b rdata0=%h exp 1000 aaaa0000", {rvalid0, rvalid1, gnt0, gnt1}, rdata0);
        end
        step();
        #1;
        n_checks++;
        if ({rvalid0, rvalid1, gnt0, gnt1} !== 4'b0001) begin
            n_fail++;
            $display("FAIL brd_n2: rv0,rv1,g0,g1 got %b exp 0001", {rvalid0, rvalid1, gnt0, gnt1});
        end
        step();
        req1 = 1'b0;
        #1;
        n_checks++;
        if ({rvalid0, rvalid1, gnt0, gnt1} !== 4'b0100 || rdata1 !== 32'hBBBB1111 || rdata0 !== 32'h0) begin
            n_fail++;
            $display("FAIL brd_n3: rv0,rv1,g0,g1 got %b rdata1=%h rdata0=%h exp 0100 bbbb1111 0", {rvalid0, rvalid1, gnt0, gnt1}, rdata1, rdata0);
        end
        step();
    endtask

    task automatic test_range();
        // Out-of-range write: granted, flagged, not written
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20000; wdata1 = 32'hCAFEF00D;
        #1;
        n_checks++;
        if ({gnt1, err1, mem_we} !== 3'b110) begin
            n_fail++;
            $display("FAIL oor_wr: gnt1,err1,mem_we got %b exp 110", {gnt1, err1, mem_we});
        end
        // Out-of-range read: no error on grant, error and zero data on response
        step();
        we1 = 1'b0;
        #1;
        n_checks++;
        if ({gnt1, err1} !== 2'b10) begin
            n_fail++;
            $display("FAIL oor_rd_gnt: gnt1,err1 got %b exp 10", {gnt1, err1});
        end
        step();
        req1 = 1'b0;
        #1;
        n_checks++;
        if ({rvalid1, err1, rvalid0, err0} !== 4'b1100 || rdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_rd_rsp: rv1,e1,rv0,e0 got %b rdata1=%h exp 1100 0", {rvalid1, err1, rvalid0, err0}, rdata1);
        end
        // Boundary address MAX_ADDR is legal: write then read back
        step();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h1FFFF; wdata1 = 32'h5A5A1234;
        #1;
        n_checks++;
        if ({gnt1, err1, mem_we} !== 3'b101 || mem_a !== 32'h1FFFF) begin
            n_fail++;
            $display("FAIL max_wr: gnt1,err1,mem_we got %b mem_a=%h exp 101 1ffff", {gnt1, err1, mem_we}, mem_a);
        end
        step();
        we1 = 1'b0;
        step();
        req1 = 1'b0;
        #1;
        n_checks++;
        if ({rvalid1, err1} !== 2'b10 || rdata1 !== 32'h5A5A1234) begin
            n_fail++;
            $display("FAIL max_rd: rv1,err1 got %b rdata1=%h exp 10 5a5a1234", {rvalid1, err1}, rdata1);
        end
        step();
    endtask

    task automatic test_reset_in_rd_wait();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
        step();
        req0 = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rvalid0, rvalid1, err0, err1, gnt0, gnt1, mem_we} !== 7'b0 || rdata0 !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_rdwait: ctrl=%b rdata0=%h exp 0000000 0", {rvalid0, rvalid1, err0, err1, gnt0, gnt1, mem_we}, rdata0);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if ({rvalid0, rvalid1} !== 2'b00) begin
                n_fail++;
                $display("FAIL rst_norsp[%0d]: rvalid0,rvalid1 got %b exp 00", i, {rvalid0, rvalid1});
            end
            step();
        end
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd1; wdata0 = 32'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd2; wdata1 = 32'h22;
        #1;
        n_checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_first_contention: gnt0,gnt1 got %b exp 10", {gnt0, gnt1});
        end
        step();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_write();
        test_read();
        test_round_robin_write();
        test_both_read();
        test_range();
        test_reset_in_rd_wait();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
